banked_memory: RTL and testbench
================================

# banked_memory

Parametrised successor to the CPU's fixed 4-byte-lane data memory. It provides a valid/ready request port, `BYTES` independent byte banks and single-cycle misaligned access to RAM, including wrap-around at the top of RAM. A multi-cycle MMIO window is reached through an ack handshake with a timeout. It sits between the load/store stage and RAM/peripherals, replacing the per-instance RAM wiring.

## Interface
Parameters:
- `BYTES`, 4: bytes per word, a power of two ≥ 2. Data width `W = 8*BYTES`. `LB = log2(BYTES)`.
- `ADDR_WIDTH`, 11: RAM byte-address bits. Each bank has `2^(ADDR_WIDTH-LB)` rows × 8 bits.
- `MMIO_BIT`, 11: `req_addr[MMIO_BIT]=1` selects MMIO. Must be ≥ `ADDR_WIDTH`.
- `MMIO_TIMEOUT`, 16: wait-state cycles before an MMIO access aborts. Must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `clk_enable` in 1: all state updates and RAM writes occur only on edges where this is high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an enabled edge when `req_valid & req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: log2 of byte count. Values > `LB` are treated as `LB`.
- `req_signed` in 1: sign-extend load result (ignored for full-word loads).
- `req_addr` in 32: byte address.
- `req_wdata` in W: store data, LSB-aligned.
- `rsp_valid` out 1: one enabled-cycle response pulse (loads and stores).
- `rsp_rdata` out W: load result. 0 for stores.
- `rsp_err` out 1: MMIO timeout; qualified by `rsp_valid`.
- `mmio_req` out 1: MMIO access pending.
- `mmio_write` out 1: MMIO write flag.
- `mmio_addr` out 32: MMIO address.
- `mmio_wdata` out W: MMIO write data.
- `mmio_size` out 2: clamped access size.
- `mmio_ack` in 1: MMIO completion.
- `mmio_rdata` in W: MMIO read data, LSB-aligned, valid with `mmio_ack`.

## Operation
- **RAM byte mapping:** byte `i` (`0 ≤ i < 2^size`) of an access at address `a` uses bank `(a+i) mod BYTES` and row `((a+i) mod 2^ADDR_WIDTH) >> LB`. Rows wrap at the top of RAM. Address bits above `ADDR_WIDTH` other than `MMIO_BIT` are ignored (aliasing).
- **Store:** write-enable only the banks touched by bytes `0..2^size-1`. Bank data is the `req_wdata` byte `i` for the mapped bank.
- **Load:** banks have a registered read. Decode registers `align = a mod BYTES` and size/signed. Result byte `i` = bank `(align+i) mod BYTES`. Bytes ≥ `2^size` are zero, or copies of bit `8*2^size-1` when `req_signed`.
- **Read during write:** a RAM load issued the cycle after a store to the same bytes returns the new data, because the store edge precedes the read edge.
- **FSM states:**
  - IDLE: `req_ready=1`. A RAM request completes here. An MMIO request latches `mmio_*`, sets `mmio_req=1`, clears the timeout counter and moves to MMIO_WAIT.
  - MMIO_WAIT: `req_ready=0`. The counter increments each enabled edge.
    - `mmio_ack=1`: `rsp_valid=1`, `rsp_err=0`, `rsp_rdata` = `mmio_rdata` truncated/extended per size and signed (stores give 0), `mmio_req=0`, return to IDLE.
    - Otherwise, when the counter reaches `MMIO_TIMEOUT`: `rsp_valid=1`, `rsp_err=1`, `rsp_rdata` all ones, `mmio_req=0`, return to IDLE.
    - If ack and timeout coincide, ack wins.
- **Reset values:** `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `mmio_req=0`, `mmio_write=0`, `mmio_addr=0`, `mmio_wdata=0`, `mmio_size=0`, state IDLE, counter 0. `req_ready` is low while `reset` is high. RAM contents are not reset.
- **Reset during MMIO_WAIT:** the access is abandoned. `mmio_req` drops at the reset edge and no response is produced.
- **`clk_enable` low:** all registers hold, including the counter and `rsp_valid`, and no RAM write occurs.

## Timing
- **RAM access** accepted at edge T: the RAM write occurs at T. `rsp_valid` is high for the enabled cycle after T, with `rsp_rdata` valid. Back-to-back accepts give one response per cycle.
- **MMIO access** accepted at edge T: `mmio_req` is high from T. With ack sampled at edge E, `rsp_valid` is high after E and `req_ready` is high in that same cycle. Minimum latency is 2 cycles.
- **Timeout:** with no ack, the response follows the `MMIO_TIMEOUT`-th enabled edge after T.
- `rsp_valid` deasserts after one enabled cycle unless a new response follows.

## Test plan
Defaults: `BYTES=4`, `ADDR_WIDTH=11`.
1. **Aligned word:** store word `0xDEADBEEF` @`0x000`, then load word @`0x000` → `rsp_valid` one cycle after accept, `rsp_rdata=0xDEADBEEF`.
2. **Misaligned:** after scenario 1, store word `0x11223344` @`0x003`.
   - Load byte @`0x003` signed → `0x00000044`.
   - Load half @`0x005` unsigned → `0x00001122`.
   - Load word @`0x002` → `0x223344AD`.
3. **Extension:** store byte `0x80` @`0x010`.
   - Signed byte load → `0xFFFFFF80`.
   - Unsigned byte load → `0x00000080`.
4. **Wrap-around:** store word `0xCAFEF00D` @`0x7FE`.
   - Load byte @`0x000` → `0xFE`.
   - Load byte @`0x001` → `0xCA`.
   - Load word @`0x7FE` → `0xCAFEF00D`.
5. **MMIO ack and timeout:**
   - Load word @`0x800`, ack on the 3rd wait cycle with `0x12345678` → `req_ready` low 3 cycles, then `rsp_rdata=0x12345678`, `rsp_err=0`.
   - No ack → response after 16 cycles, `rsp_err=1`, `rsp_rdata=0xFFFFFFFF`, `mmio_req=0`.
6. **Reset and enable:**
   - Reset asserted in MMIO_WAIT → `mmio_req=0` next cycle, no `rsp_valid`, IDLE afterwards.
   - `clk_enable` held low for 5 cycles mid-wait → timeout deferred by exactly 5 cycles.

Source files
------------

// File: rtl/banked_memory.sv
// banked_memory: BYTES independent byte-wide RAM banks behind a valid/ready
// request port, with single-cycle misaligned access that wraps at the top of
// RAM. A separate MMIO window is reached through an ack handshake guarded by
// a wait-state timeout.
module banked_memory #(
    parameter int BYTES        = 4,
    parameter int ADDR_WIDTH   = 11,
    parameter int MMIO_BIT     = 11,
    parameter int MMIO_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_enable,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [8*BYTES-1:0]   req_wdata,
    output logic                 rsp_valid,
    output logic [8*BYTES-1:0]   rsp_rdata,
    output logic                 rsp_err,
    output logic                 mmio_req,
    output logic                 mmio_write,
    output logic [31:0]          mmio_addr,
    output logic [8*BYTES-1:0]   mmio_wdata,
    output logic [1:0]           mmio_size,
    input  logic                 mmio_ack,
    input  logic [8*BYTES-1:0]   mmio_rdata
);

    localparam int W    = 8 * BYTES;
    localparam int LB   = $clog2(BYTES);
    localparam int RW   = ADDR_WIDTH - LB;
    localparam int ROWS = 1 << RW;
    localparam int CW   = $clog2(MMIO_TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    // Keep the low 2^size bytes of d; fill the rest with zero or the sign bit.
    function automatic logic [W-1:0] f_format(input logic [W-1:0] d,
                                              input logic [1:0]   sz,
                                              input logic         sgn);
        logic [W-1:0] res;
        logic         s;
        int           n;
        n   = 1 << sz;
        s   = sgn & d[8*n-1];
        res = '0;
        for (int i = 0; i < BYTES; i++) begin
            res[8*i +: 8] = (i < n) ? d[8*i +: 8] : {8{s}};
        end
        return res;
    endfunction

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_timeout;
    logic            w_is_mmio;
    logic            w_accept;
    logic            w_ram_wr;
    logic            w_ram_rd;
    logic [1:0]      w_size;
    logic [LB:0]     w_nbytes;
    logic [LB-1:0]   w_align;
    logic [RW-1:0]   w_row_base;
    logic [W-1:0]    w_rd_word;
    logic [2*W-1:0]  w_rd_rot;
    logic [W-1:0]    w_ram_raw;
    logic            w_unused;

    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic            r_rsp_ram;
    logic [W-1:0]    r_rsp_data;
    logic [LB-1:0]   r_align;
    logic [1:0]      r_size;
    logic            r_signed;
    logic            r_mmio_req;
    logic            r_mmio_write;
    logic [31:0]     r_mmio_addr;
    logic [W-1:0]    r_mmio_wdata;
    logic [1:0]      r_mmio_size;

    assign w_size     = (req_size > 2'(LB)) ? 2'(LB) : req_size;
    assign w_nbytes   = {{LB{1'b0}}, 1'b1} << w_size;
    assign w_is_mmio  = req_addr[MMIO_BIT];
    assign w_accept   = req_valid & req_ready;
    assign w_ram_wr   = clk_enable & w_accept & ~w_is_mmio & req_write;
    assign w_ram_rd   = clk_enable & w_accept & ~w_is_mmio & ~req_write;
    assign w_align    = req_addr[LB-1:0];
    assign w_row_base = req_addr[ADDR_WIDTH-1:LB];
    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_timeout  = (w_cnt_inc == CW'(MMIO_TIMEOUT));
    // Upper address bits alias onto RAM; only MMIO_BIT is decoded.
    assign w_unused   = ^req_addr;

    for (genvar b = 0; b < BYTES; b++) begin : g_bank
        // NOTE: RAM contents are deliberately not reset; only control state is.
        logic [7:0]    r_mem [ROWS];
        logic [7:0]    r_rd;
        logic [LB-1:0] w_off;
        logic [RW-1:0] w_row;
        logic [W-1:0]  w_wshift;
        logic          w_touch;

        // Byte index within the access that lands in this bank; banks below
        // the start alignment hold the following row (wrapping at the top).
        assign w_off    = LB'(b) - w_align;
        assign w_row    = (LB'(b) < w_align) ? w_row_base + RW'(1) : w_row_base;
        assign w_touch  = ({1'b0, w_off} < w_nbytes);
        assign w_wshift = req_wdata >> {w_off, 3'b000};

        // Bank write of the mapped store byte, and registered bank read.
        // NOTE: clocked state always uses non-blocking assignments.
        always_ff @(posedge clk) begin
            if (w_ram_wr && w_touch) r_mem[w_row] <= w_wshift[7:0];
            if (w_ram_rd)            r_rd         <= r_mem[w_row];
        end

        assign w_rd_word[8*b +: 8] = r_rd;
    end

    // Rotate the bank outputs so the byte at the access address is byte 0.
    assign w_rd_rot  = {w_rd_word, w_rd_word} >> {r_align, 3'b000};
    assign w_ram_raw = w_rd_rot[W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset)           r_state <= S_IDLE;
        else if (clk_enable) r_state <= w_state_nxt;
    end

    // Next-state logic: MMIO requests wait for ack or timeout.
    always_comb begin
        // NOTE: default assignment first so no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_mmio) w_state_nxt = S_WAIT;
            S_WAIT: if (mmio_ack || w_timeout) w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: accept only in IDLE and never while reset is high.
    always_comb begin
        req_ready = 1'b0;
        if (r_state == S_IDLE && !reset) req_ready = 1'b1;
    end

    // Response, load-decode, MMIO latch and timeout counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_ram    <= 1'b0;
            r_rsp_data   <= '0;
            r_align      <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_mmio_req   <= 1'b0;
            r_mmio_write <= 1'b0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= '0;
            r_mmio_size  <= '0;
            r_cnt        <= '0;
        end else if (clk_enable) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mmio) begin
                        r_mmio_req   <= 1'b1;
                        r_mmio_write <= req_write;
                        r_mmio_addr  <= req_addr;
                        r_mmio_wdata <= req_wdata;
                        r_mmio_size  <= w_size;
                        r_signed     <= req_signed;
                        r_cnt        <= '0;
                    end else if (w_accept) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_ram   <= ~req_write;
                        r_rsp_data  <= '0;
                        r_align     <= w_align;
                        r_size      <= w_size;
                        r_signed    <= req_signed;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (mmio_ack) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_ram   <= 1'b0;
                        r_rsp_data  <= r_mmio_write ? '0
                                     : f_format(mmio_rdata, r_mmio_size, r_signed);
                        r_mmio_req  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_ram   <= 1'b0;
                        r_rsp_data  <= '1;
                        r_mmio_req  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_rdata  = r_rsp_ram ? f_format(w_ram_raw, r_size, r_signed) : r_rsp_data;
    assign mmio_req   = r_mmio_req;
    assign mmio_write = r_mmio_write;
    assign mmio_addr  = r_mmio_addr;
    assign mmio_wdata = r_mmio_wdata;
    assign mmio_size  = r_mmio_size;

endmodule

// File: tb/tb_banked_memory.sv
// Self-checking bench for banked_memory (BYTES=4, ADDR_WIDTH=11).
// Expected responses are queued when requests are driven and compared by a
// monitor as the DUT responds; scenario tasks also check timing inline.
module tb_banked_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mmio_req;
    logic        mmio_write;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [1:0]  mmio_size;
    logic        mmio_ack = 1'b0;
    logic [31:0] mmio_rdata = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic       last_en = 1'b0;
    logic [7:0] model_mem [2048];

    always #5 clk = ~clk;

    banked_memory #(
        .BYTES(4), .ADDR_WIDTH(11), .MMIO_BIT(11), .MMIO_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mmio_req(mmio_req), .mmio_write(mmio_write),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_size(mmio_size),
        .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata)
    );

    // Remember whether the last rising edge was enabled: a held rsp_valid
    // across disabled edges is the same response, not a new one.
    always @(posedge clk) last_en <= clk_enable;

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (last_en && rsp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response",
                         rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
        end
    end

    // Reference load from a flat byte-addressed RAM image.
    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                               input logic [31:0] addr);
        int          n;
        logic [31:0] v;
        n = (sz > 2'd2) ? 4 : (1 << sz);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(model_mem[(addr + 32'(i)) & 32'h7FF]) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Present one request for one edge; called just after a rising edge.
    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
    endtask

    task automatic ram_store(input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd);
        int n;
        n = (sz > 2'd2) ? 4 : (1 << sz);
        for (int i = 0; i < n; i++) model_mem[(addr + 32'(i)) & 32'h7FF] = wd[8*i +: 8];
        sb.push_back('{32'h0, 1'b0});
        drive_req(1'b1, sz, 1'b0, addr, wd);
    endtask

    task automatic ram_load(input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                            input logic [31:0] expv);
        sb.push_back('{expv, 1'b0});
        drive_req(1'b0, sz, sg, addr, 32'h0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        logic [31:0] got [9];
        string       nm [9];
        reset = 1'b1;
        idle_cycles(3);
        got[0] = 32'(rsp_valid);  nm[0] = "reset_rsp_valid";
        got[1] = rsp_rdata;       nm[1] = "reset_rsp_rdata";
        got[2] = 32'(rsp_err);    nm[2] = "reset_rsp_err";
        got[3] = 32'(mmio_req);   nm[3] = "reset_mmio_req";
        got[4] = 32'(mmio_write); nm[4] = "reset_mmio_write";
        got[5] = mmio_addr;       nm[5] = "reset_mmio_addr";
        got[6] = mmio_wdata;      nm[6] = "reset_mmio_wdata";
        got[7] = 32'(mmio_size);  nm[7] = "reset_mmio_size";
        got[8] = 32'(req_ready);  nm[8] = "reset_req_ready";
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== 32'h0) begin
                errors++;
                $display("FAIL %s: got %h, required 0", nm[i], got[i]);
            end
        end
        reset = 1'b0;
        idle_cycles(1);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_aligned_word;
        ram_store(2'd2, 32'h000, 32'hDEADBEEF);
        ram_load(2'd2, 1'b0, 32'h000, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL aligned_latency: got valid=%b rdata=%h, required valid=1 rdata=deadbeef",
                     rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse_width: got valid=%b, required 0", rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned;
        ram_store(2'd2, 32'h003, 32'h11223344);
        ram_load(2'd0, 1'b1, 32'h003, 32'h00000044);
        ram_load(2'd1, 1'b0, 32'h005, 32'h00001122);
        ram_load(2'd2, 1'b0, 32'h002, 32'h223344AD);
        idle_cycles(2);
    endtask

    task automatic test_extension;
        ram_store(2'd0, 32'h010, 32'h00000080);
        ram_load(2'd0, 1'b1, 32'h010, 32'hFFFFFF80);
        ram_load(2'd0, 1'b0, 32'h010, 32'h00000080);
        ram_load(2'd1, 1'b1, 32'h000, 32'hFFFFBEEF);
        ram_load(2'd3, 1'b1, 32'h000, 32'h44ADBEEF);
        idle_cycles(2);
    endtask

    task automatic test_wrap;
        ram_store(2'd2, 32'h7FE, 32'hCAFEF00D);
        ram_load(2'd0, 1'b0, 32'h000, 32'h000000FE);
        ram_load(2'd0, 1'b0, 32'h001, 32'h000000CA);
        ram_load(2'd2, 1'b0, 32'h7FE, 32'hCAFEF00D);
        ram_load(2'd2, 1'b0, 32'h17FE, 32'hCAFEF00D);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        sg;
        for (int i = 0; i < 16; i++) ram_store(2'd2, 32'h100 + 32'(4 * i), $urandom);
        for (int i = 0; i < 40; i++) begin
            a  = 32'h100 + 32'($urandom_range(0, 60));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3) ram_store(sz, a, $urandom);
            else                         ram_load(sz, sg, a, model_load(sz, sg, a));
        end
        idle_cycles(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_mmio_ack;
        sb.push_back('{32'h12345678, 1'b0});
        drive_req(1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
        checks++;
        if (mmio_req !== 1'b1 || mmio_addr !== 32'h800 || mmio_write !== 1'b0 || mmio_size !== 2'd2) begin
            errors++;
            $display("FAIL mmio_latch: got req=%b addr=%h wr=%b size=%0d, required 1 800 0 2",
                     mmio_req, mmio_addr, mmio_write, mmio_size);
        end
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin mmio_ack = 1'b1; mmio_rdata = 32'h12345678; end
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL mmio_wait_ready: cycle %0d got %b, required 0", k, req_ready);
            end
            @(posedge clk); #1;
        end
        mmio_ack = 1'b0; mmio_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || mmio_req !== 1'b0) begin
            errors++;
            $display("FAIL mmio_done: got valid=%b ready=%b mreq=%b, required 1 1 0",
                     rsp_valid, req_ready, mmio_req);
        end
        @(posedge clk); #1;
        // Minimum latency, signed half load.
        sb.push_back('{32'hFFFF8001, 1'b0});
        drive_req(1'b0, 2'd1, 1'b1, 32'h804, 32'h0);
        mmio_ack = 1'b1; mmio_rdata = 32'hABCD8001;
        @(posedge clk); #1;
        mmio_ack = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || mmio_size !== 2'd1) begin
            errors++;
            $display("FAIL mmio_min_latency: got valid=%b size=%0d, required 1 1", rsp_valid, mmio_size);
        end
        @(posedge clk); #1;
        // Store with oversized request size: clamped, response data zero.
        sb.push_back('{32'h0, 1'b0});
        drive_req(1'b1, 2'd3, 1'b0, 32'h900, 32'hCAFEBABE);
        checks++;
        if (mmio_write !== 1'b1 || mmio_wdata !== 32'hCAFEBABE || mmio_size !== 2'd2) begin
            errors++;
            $display("FAIL mmio_store_latch: got wr=%b wdata=%h size=%0d, required 1 cafebabe 2",
                     mmio_write, mmio_wdata, mmio_size);
        end
        mmio_ack = 1'b1; mmio_rdata = 32'hDEADDEAD;
        @(posedge clk); #1;
        mmio_ack = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_timeout;
        int   n;
        logic mr;
        n  = 0;
        mr = 1'b0;
        sb.push_back('{32'hFFFFFFFF, 1'b1});
        drive_req(1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 15) mr = mmio_req;
            if (rsp_valid === 1'b1) begin n = e; break; end
        end
        checks++;
        if (n != 16 || mr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_latency: got edge %0d mreq=%b, required edge 16 mreq=1", n, mr);
        end
        checks++;
        if (mmio_req !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: got mreq=%b ready=%b, required 0 1", mmio_req, req_ready);
        end
        idle_cycles(2);
    endtask

    task automatic test_ack_wins;
        sb.push_back('{32'h000000AA, 1'b0});
        drive_req(1'b0, 2'd0, 1'b0, 32'h800, 32'h0);
        idle_cycles(15);
        mmio_ack = 1'b1; mmio_rdata = 32'h123456AA;
        @(posedge clk); #1;
        mmio_ack = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h000000AA) begin
            errors++;
            $display("FAIL ack_wins: got valid=%b err=%b rdata=%h, required 1 0 000000aa",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_wait;
        logic seen;
        drive_req(1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
        idle_cycles(2);
        reset = 1'b1;
        idle_cycles(1);
        checks++;
        if (mmio_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got mreq=%b valid=%b ready=%b, required 0 0 0",
                     mmio_req, rsp_valid, req_ready);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_rsp: got spurious=%b ready=%b, required 0 1", seen, req_ready);
        end
        ram_load(2'd0, 1'b0, 32'h000, 32'h000000FE);
        idle_cycles(2);
    endtask

    task automatic test_clk_enable;
        int n;
        n = 0;
        sb.push_back('{32'hFFFFFFFF, 1'b1});
        drive_req(1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (e == 4) clk_enable = 1'b0;
            if (e == 9) clk_enable = 1'b1;
            if (rsp_valid === 1'b1) begin n = e; break; end
        end
        checks++;
        if (n != 21) begin
            errors++;
            $display("FAIL enable_deferred_timeout: got edge %0d, required edge 21", n);
        end
        clk_enable = 1'b0;
        idle_cycles(2);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL enable_hold_rsp: got valid=%b err=%b, required 1 1", rsp_valid, rsp_err);
        end
        clk_enable = 1'b1;
        idle_cycles(1);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_rsp_drop: got %b, required 0", rsp_valid);
        end
        // A store presented only on disabled edges must not reach RAM.
        clk_enable = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_addr = 32'h010; req_wdata = 32'h00000055;
        idle_cycles(2);
        req_valid = 1'b0;
        clk_enable = 1'b1;
        ram_load(2'd0, 1'b0, 32'h010, 32'h00000080);
        idle_cycles(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_aligned_word();
        test_misaligned();
        test_extension();
        test_wrap();
        test_back_to_back();
        test_mmio_ack();
        test_timeout();
        test_ack_wins();
        test_reset_mid_wait();
        test_clk_enable();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d outstanding responses, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
